sram_port_arbiter: RTL and testbench

// - Shares the single async 16-bit SRAM between three requesters: fix-layer SROM tile fetch (FIX),

---
 rtl/sram_port_arbiter_pkg.sv | 26 ++
 rtl/sram_port_arbiter_if.sv | 50 +++++
 rtl/sram_arb_pick.sv | 56 +++++
 rtl/sram_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// neo_sram_pkg: shared types and defaults for the SRAM port arbiter slice.
//   state_t    - arbiter FSM states (IDLE, ACC, ACC2, DONE, TURN)
//   req_id_t   - requester identifiers (REQ_FIX, REQ_HOST, REQ_CPU)
//   WAIT_CYC_DEF / ADDR_W_DEF - default extra wait cycles and SRAM word address width
`timescale 1ns/1ps
package neo_sram_pkg;

  // 6 extra cycles -> strobes held 7 cycles, >= 55 ns at 93 MHz
  localparam int WAIT_CYC_DEF = 6;
  localparam int ADDR_W_DEF   = 17;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC  = 3'd1,
    ACC2 = 3'd2,
    DONE = 3'd3,
    TURN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    REQ_FIX  = 2'd0,
    REQ_HOST = 2'd1,
    REQ_CPU  = 2'd2
  } req_id_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: requester-side bundle of the SRAM arbiter.
//   FIX  : fix_req/fix_addr in, fix_ack/fix_rdata out (16-bit reads)
//   HOST : host_rd/host_wr/host_addr/host_wdata in, host_rdata/host_ack/host_busy out (32-bit)
//   CPU  : cpu_req/cpu_we/cpu_addr/cpu_be_n/cpu_wdata in, cpu_rdata/cpu_ack out (16-bit)
// Handshake: every request is a level held until its 1-cycle ack pulse; read data
// is valid in the ack cycle. The requester drops its request after seeing the ack.
// modport master = requester side, modport slave = arbiter side.
`timescale 1ns/1ps
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              fix_req;
  logic [ADDR_W-1:0] fix_addr;
  logic              fix_ack;
  logic [15:0]       fix_rdata;

  logic              host_rd;
  logic              host_wr;
  logic [24:0]       host_addr;
  logic [31:0]       host_wdata;
  logic [31:0]       host_rdata;
  logic              host_ack;
  logic              host_busy;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_be_n;
  logic [15:0]       cpu_wdata;
  logic [15:0]       cpu_rdata;
  logic              cpu_ack;

  modport master (
    output fix_req, fix_addr,
    input  fix_ack, fix_rdata,
    output host_rd, host_wr, host_addr, host_wdata,
    input  host_rdata, host_ack, host_busy,
    output cpu_req, cpu_we, cpu_addr, cpu_be_n, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  fix_req, fix_addr,
    output fix_ack, fix_rdata,
    input  host_rd, host_wr, host_addr, host_wdata,
    output host_rdata, host_ack, host_busy,
    input  cpu_req, cpu_we, cpu_addr, cpu_be_n, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: grant selection for the SRAM arbiter.
//   FIX has strict priority; HOST and CPU share a 2-way round-robin pointer
//   that flips to the other requester after every HOST or CPU grant.
// Ports:
//   CLK, nRESET          clock, async active-low reset (pointer resets to HOST)
//   arb_en               arbiter is in IDLE and may grant this cycle
//   fix_req/host_req/cpu_req  pending requests
//   gnt_valid, gnt_id    combinational grant (only while arb_en)
`timescale 1ns/1ps
module sram_arb_pick
  import neo_sram_pkg::*;
(
  input  logic    CLK,
  input  logic    nRESET,
  input  logic    arb_en,
  input  logic    fix_req,
  input  logic    host_req,
  input  logic    cpu_req,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t ptr_q;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ_FIX;
    if (arb_en) begin
      if (fix_req) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_FIX;
      end else if (host_req && cpu_req) begin
        gnt_valid = 1'b1;
        gnt_id    = ptr_q;
      end else if (host_req) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_HOST;
      end else if (cpu_req) begin
        gnt_valid = 1'b1;
        gnt_id    = REQ_CPU;
      end
    end
  end

  // Pointer only ever holds REQ_HOST or REQ_CPU; FIX grants leave it alone.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ptr_q <= REQ_HOST;
    end else if (gnt_valid && gnt_id == REQ_HOST) begin
      ptr_q <= REQ_CPU;
    end else if (gnt_valid && gnt_id == REQ_CPU) begin
      ptr_q <= REQ_HOST;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async 16-bit SRAM between FIX tile fetch,
// the HOST 32-bit bridge and the 68K CPU backup-RAM port.
// Ports:
//   CLK, nRESET      core clock, async active-low reset
//   bus (slave)      requester handshakes, see sram_port_arbiter_if
//   sram_a, sram_dq  SRAM address and bidirectional data (driven only during writes)
//   sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  active-low SRAM strobes
//   dbg_state        current FSM state
// Each 16-bit access holds its strobes for WAIT_CYC+1 cycles. A HOST access is
// two back-to-back words (even then odd) that nothing can interleave. Every
// write is followed by one TURN cycle with the bus released.
// All strobes, address and write data are registered so the pins never glitch.
`timescale 1ns/1ps
module sram_port_arbiter
  import neo_sram_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
)(
  input  logic              CLK,
  input  logic              nRESET,
  sram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output state_t            dbg_state
);

  localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  req_id_t           gnt_q;
  logic              we_q;
  logic [1:0]        be_n_q;
  logic [15:0]       wd_lo_q;
  logic [ADDR_W-1:0] a_q;
  logic [15:0]       dq_out_q;
  logic              dq_oe_q;
  logic              oe_n_q, we_n_q, ub_n_q, lb_n_q;
  logic [15:0]       fix_rdata_q, cpu_rdata_q;
  logic [31:0]       host_rdata_q;
  logic              busy_q;

  logic              gnt_valid;
  req_id_t           gnt_id;
  logic              cnt_last;
  logic              in_access;
  logic              access_d;
  logic              we_d;
  logic [1:0]        be_n_d;

  logic              new_we;
  logic [ADDR_W-1:0] new_addr;
  logic [15:0]       new_wd_hi, new_wd_lo;
  logic [1:0]        new_be_n;

  // Host byte address bits outside the SRAM word-pair range carry no meaning here.
  logic unused_host_bits;
  assign unused_host_bits = ^{bus.host_addr[24:ADDR_W+1], bus.host_addr[1:0]};

  sram_arb_pick u_pick (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .arb_en    (state_q == IDLE),
    .fix_req   (bus.fix_req),
    .host_req  (bus.host_rd | bus.host_wr),
    .cpu_req   (bus.cpu_req),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Transaction fields of whichever requester is being granted this cycle.
  always_comb begin
    new_we    = 1'b0;
    new_addr  = bus.fix_addr;
    new_wd_hi = 16'h0000;
    new_wd_lo = 16'h0000;
    new_be_n  = 2'b00;
    case (gnt_id)
      REQ_HOST: begin
        new_we    = bus.host_wr;
        new_addr  = {bus.host_addr[ADDR_W:2], 1'b0};
        new_wd_hi = bus.host_wdata[31:16];
        new_wd_lo = bus.host_wdata[15:0];
      end
      REQ_CPU: begin
        new_we    = bus.cpu_we;
        new_addr  = bus.cpu_addr;
        new_wd_hi = bus.cpu_wdata;
        new_wd_lo = bus.cpu_wdata;
        new_be_n  = bus.cpu_be_n;
      end
      default: ;
    endcase
  end

  assign cnt_last  = (cnt_q == CNT_LAST);
  assign in_access = (state_q == ACC) || (state_q == ACC2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_valid) state_d = ACC;
      ACC:     if (cnt_last)  state_d = (gnt_q == REQ_HOST) ? ACC2 : DONE;
      ACC2:    if (cnt_last)  state_d = DONE;
      DONE:    state_d = we_q ? TURN : IDLE;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe registers are loaded from the next state so they assert exactly
  // in the first ACC cycle and release in the DONE cycle.
  assign access_d = (state_d == ACC) || (state_d == ACC2);
  assign we_d     = gnt_valid ? new_we   : we_q;
  assign be_n_d   = gnt_valid ? new_be_n : be_n_q;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      gnt_q        <= REQ_FIX;
      we_q         <= 1'b0;
      be_n_q       <= 2'b11;
      wd_lo_q      <= 16'h0000;
      a_q          <= '0;
      dq_out_q     <= 16'h0000;
      dq_oe_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      fix_rdata_q  <= 16'h0000;
      cpu_rdata_q  <= 16'h0000;
      host_rdata_q <= 32'h0000_0000;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (in_access) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (gnt_valid) begin
        gnt_q    <= gnt_id;
        we_q     <= new_we;
        be_n_q   <= new_be_n;
        wd_lo_q  <= new_wd_lo;
        a_q      <= new_addr;
        dq_out_q <= new_wd_hi;
      end else if (state_q == ACC && state_d == ACC2) begin
        // HOST second word: odd address, low half of the write data
        a_q[0]   <= 1'b1;
        dq_out_q <= wd_lo_q;
      end

      oe_n_q  <= !(access_d && !we_d);
      we_n_q  <= !(access_d && we_d);
      ub_n_q  <= access_d ? be_n_d[1] : 1'b1;
      lb_n_q  <= access_d ? be_n_d[0] : 1'b1;
      dq_oe_q <= access_d && we_d;

      if (in_access && cnt_last && !we_q) begin
        case (gnt_q)
          REQ_FIX:  fix_rdata_q <= sram_dq;
          REQ_CPU:  cpu_rdata_q <= sram_dq;
          REQ_HOST: begin
            if (state_q == ACC) host_rdata_q[31:16] <= sram_dq;
            else                host_rdata_q[15:0]  <= sram_dq;
          end
          default: ;
        endcase
      end

      if (gnt_valid && gnt_id == REQ_HOST) begin
        busy_q <= 1'b1;
      end else if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign sram_a    = a_q;
  assign sram_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_ub_n = ub_n_q;
  assign sram_lb_n = lb_n_q;
  assign dbg_state = state_q;

  assign bus.fix_ack    = (state_q == DONE) && (gnt_q == REQ_FIX);
  assign bus.host_ack   = (state_q == DONE) && (gnt_q == REQ_HOST);
  assign bus.cpu_ack    = (state_q == DONE) && (gnt_q == REQ_CPU);
  assign bus.fix_rdata  = fix_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_busy  = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural async SRAM model, directed accesses
// from each requester, arbitration order scenarios and a reset during a write.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  import neo_sram_pkg::*;

  localparam int AW = 17;
  localparam int WC = 6;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRESET = 1'b1;
  always #5 CLK = ~CLK;

  sram_port_arbiter_if #(.ADDR_W(AW)) bus();

  wire  [15:0]   sram_dq;
  logic [AW-1:0] sram_a;
  logic          sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  state_t        dbg_state;

  sram_port_arbiter #(.WAIT_CYC(WC), .ADDR_W(AW)) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .bus       (bus),
    .sram_a    (sram_a),
    .sram_dq   (sram_dq),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [15:0]   mem [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [15:0]   pre_data = '0;
  // probe driver: a released bus reads back the probe pattern
  logic          probe_en = 1'b0;
  localparam logic [15:0] PROBE = 16'h5AA5;

  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_a] : 16'hzzzz;
  assign sram_dq = probe_en ? PROBE : 16'hzzzz;

  always @(negedge CLK) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!sram_we_n) begin
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq[15:8];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  exp_q[$];
  logic [31:0] exp_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic preset(input logic [AW-1:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge CLK);
    #1 pre_en = 1'b0;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 30; i++) begin
      if (dbg_state == IDLE) break;
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic drop_req(input int which);
    case (which)
      0:       bus.fix_req = 1'b0;
      1:       begin bus.host_rd = 1'b0; bus.host_wr = 1'b0; end
      default: bus.cpu_req = 1'b0;
    endcase
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      0:       return bus.fix_ack;
      1:       return bus.host_ack;
      default: return bus.cpu_ack;
    endcase
  endfunction

  // Request already raised at a negedge in IDLE (cycle 0); counts cycles to ack.
  task automatic wait_ack(input int which, output int lat, output int act_cnt,
                          output int busy_cnt, output logic [AW-1:0] a_seen,
                          output logic ub_seen, output logic lb_seen);
    lat = -1; act_cnt = 0; busy_cnt = 0; a_seen = '1; ub_seen = 1'b1; lb_seen = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!sram_oe_n || !sram_we_n) begin
        if (act_cnt == 0) begin
          a_seen = sram_a; ub_seen = sram_ub_n; lb_seen = sram_lb_n;
        end
        act_cnt++;
      end
      if (ack_of(which)) begin
        lat = n;
        drop_req(which);
        break;
      end
      if (bus.host_busy) busy_cnt++;
    end
    if (lat < 0) drop_req(which);
  endtask

  // Runs until every queued ack has been seen, checking order and read data.
  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (bus.fix_ack || bus.host_ack || bus.cpu_ack) begin
        logic [1:0]  id;
        logic [31:0] d;
        if (bus.fix_ack)       begin id = REQ_FIX;  d = {16'h0, bus.fix_rdata}; end
        else if (bus.host_ack) begin id = REQ_HOST; d = bus.host_rdata; end
        else                   begin id = REQ_CPU;  d = {16'h0, bus.cpu_rdata}; end
        check("grant_order", {30'h0, id}, {30'h0, exp_q.pop_front()});
        check("grant_data", d, exp_d.pop_front());
        drop_req(int'(id));
      end
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    exp_d.delete();
  endtask

  // ---------------- stimulus ----------------
  int            lat, act, busy;
  logic [AW-1:0] a_seen;
  logic          ub_s, lb_s;
  int            host_cyc, fix_cyc, split;

  initial begin
    bus.fix_req = 1'b0;  bus.fix_addr = '0;
    bus.host_rd = 1'b0;  bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0;  bus.cpu_be_n = 2'b11;
    bus.cpu_wdata = '0;

    // reset state
    #1 nRESET = 1'b0;
    repeat (2) @(negedge CLK);
    probe_en = 1'b1;
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'b1111);
    check("rst_dq_z", sram_dq, PROBE);
    check("rst_addr", sram_a, 0);
    check("rst_acks", {bus.fix_ack, bus.host_ack, bus.cpu_ack, bus.host_busy}, 0);
    check("rst_rdata", {bus.fix_rdata, bus.cpu_rdata}, 0);
    check("rst_host_rdata", bus.host_rdata, 0);
    probe_en = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    preset(17'h1ABCD, 16'h5A3C);
    preset(17'h00100, 16'hAB00);

    // FIX read
    go_idle();
    bus.fix_addr = 17'h1ABCD;
    bus.fix_req  = 1'b1;
    wait_ack(0, lat, act, busy, a_seen, ub_s, lb_s);
    check("fix_lat", lat, WC + 2);
    check("fix_oe_cycles", act, WC + 1);
    check("fix_addr", a_seen, 17'h1ABCD);
    check("fix_bytes", {ub_s, lb_s}, 2'b00);
    check("fix_rdata", bus.fix_rdata, 16'h5A3C);

    // HOST write, then TURN
    go_idle();
    bus.host_addr  = 25'h0000010;
    bus.host_wdata = 32'hDEADBEEF;
    bus.host_wr    = 1'b1;
    wait_ack(1, lat, act, busy, a_seen, ub_s, lb_s);
    check("hwr_lat", lat, 2 * WC + 3);
    check("hwr_we_cycles", act, 2 * (WC + 1));
    check("hwr_busy_cycles", busy, 2 * WC + 2);
    check("hwr_addr", a_seen, 17'h00008);
    @(posedge CLK);
    @(negedge CLK);
    probe_en = 1'b1;
    #1;
    check("turn_state", dbg_state, TURN);
    check("turn_strobes", {sram_oe_n, sram_we_n}, 2'b11);
    check("turn_dq_z", sram_dq, PROBE);
    check("turn_busy", bus.host_busy, 1'b0);
    probe_en = 1'b0;
    check("hwr_even", mem[17'h00008], 16'hDEAD);
    check("hwr_odd", mem[17'h00009], 16'hBEEF);

    // HOST read back
    go_idle();
    bus.host_rd = 1'b1;
    wait_ack(1, lat, act, busy, a_seen, ub_s, lb_s);
    check("hrd_lat", lat, 2 * WC + 3);
    check("hrd_rdata", bus.host_rdata, 32'hDEADBEEF);

    // CPU byte write, low byte only
    go_idle();
    bus.cpu_addr  = 17'h00100;
    bus.cpu_wdata = 16'h1234;
    bus.cpu_be_n  = 2'b10;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    wait_ack(2, lat, act, busy, a_seen, ub_s, lb_s);
    check("cwr_lat", lat, WC + 2);
    check("cwr_bytes", {ub_s, lb_s}, 2'b10);
    check("cwr_mem", mem[17'h00100], 16'hAB34);

    // CPU read
    go_idle();
    bus.cpu_we   = 1'b0;
    bus.cpu_be_n = 2'b00;
    bus.cpu_req  = 1'b1;
    wait_ack(2, lat, act, busy, a_seen, ub_s, lb_s);
    check("crd_lat", lat, WC + 2);
    check("crd_rdata", bus.cpu_rdata, 16'hAB34);

    // FIX + HOST + CPU raised together
    go_idle();
    bus.host_addr = 25'h0000010;
    bus.fix_req = 1'b1; bus.host_rd = 1'b1; bus.cpu_req = 1'b1;
    exp_q.push_back(REQ_FIX);  exp_d.push_back(32'h00005A3C);
    exp_q.push_back(REQ_HOST); exp_d.push_back(32'hDEADBEEF);
    exp_q.push_back(REQ_CPU);  exp_d.push_back(32'h0000AB34);
    drain();

    // HOST alone moves the pointer to CPU; then HOST+CPU together -> CPU first
    go_idle();
    bus.host_rd = 1'b1;
    wait_ack(1, lat, act, busy, a_seen, ub_s, lb_s);
    go_idle();
    bus.host_rd = 1'b1; bus.cpu_req = 1'b1;
    exp_q.push_back(REQ_CPU);  exp_d.push_back(32'h0000AB34);
    exp_q.push_back(REQ_HOST); exp_d.push_back(32'hDEADBEEF);
    drain();

    // FIX raised during a HOST write waits for HOST DONE and TURN
    go_idle();
    bus.host_addr  = 25'h0000020;
    bus.host_wdata = 32'hCAFEF00D;
    bus.host_wr    = 1'b1;
    bus.fix_addr   = 17'h1ABCD;
    host_cyc = -1; fix_cyc = -1; split = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (n == 3) bus.fix_req = 1'b1;
      if (host_cyc < 0 && !sram_oe_n && sram_a == 17'h1ABCD) split++;
      if (bus.host_ack) begin host_cyc = n; bus.host_wr = 1'b0; end
      if (bus.fix_ack) begin fix_cyc = n; bus.fix_req = 1'b0; break; end
    end
    bus.fix_req = 1'b0; bus.host_wr = 1'b0;
    check("prio_host_ack", host_cyc, 2 * WC + 3);
    check("prio_fix_ack", fix_cyc, 2 * WC + 3 + 2 + WC + 2);
    check("prio_no_split", split, 0);
    check("prio_fix_rdata", bus.fix_rdata, 16'h5A3C);
    check("prio_even", mem[17'h00010], 16'hCAFE);
    check("prio_odd", mem[17'h00011], 16'hF00D);

    // reset asserted in the middle of a CPU write
    go_idle();
    bus.cpu_addr  = 17'h00101;
    bus.cpu_wdata = 16'h0F0F;
    bus.cpu_be_n  = 2'b00;
    bus.cpu_we    = 1'b1;
    bus.cpu_req   = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      @(negedge CLK);
    end
    check("mid_pre_we", sram_we_n, 1'b0);
    #2 nRESET = 1'b0;
    probe_en = 1'b1;
    #1;
    check("mid_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'b1111);
    check("mid_dq_z", sram_dq, PROBE);
    check("mid_state", dbg_state, IDLE);
    probe_en = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
